// File: rtl/fp_div_seq.sv
//==============================================================================
// Module      : fp_div_seq
// Description : Sequential IEEE-754 single-precision divider (result = A / B).
//               Restoring radix-2 mantissa division producing one quotient bit
//               per cycle, followed by normalisation and round-to-nearest-even.
//               Shares the start/done/result interface of the FP multiplier.
// Ports       : clk, reset (async, active-high)
//               start, A, B            -> launch a divide (accepted in IDLE)
//               busy, done, result     -> status pulse and held quotient
//               overflow/underflow/div_by_zero/invalid flags, held with result
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fp_div_seq #(
    parameter int QBITS = 26,
    parameter int EXP_W = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        overflow_flag,
    output logic        underflow_flag,
    output logic        div_by_zero_flag,
    output logic        invalid_flag
);

    localparam int CNT_W = $clog2(QBITS);
    localparam logic [31:0] c_QNAN = 32'h7FC0_0000;
    localparam logic signed [EXP_W-1:0] c_BIAS    = EXP_W'(127);
    localparam logic signed [EXP_W-1:0] c_EXP_MAX = EXP_W'(255);
    localparam logic signed [EXP_W-1:0] c_EXP_MIN = EXP_W'(0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_DIV   = 3'd2,
        S_NORM  = 3'd3,
        S_ROUND = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                   state_q, state_d;
    logic [31:0]              a_q, b_q;
    logic [24:0]              rem_q;
    logic [23:0]              mb_q;
    logic [QBITS-1:0]         q_q;
    logic [CNT_W-1:0]         cnt_q;
    logic signed [EXP_W-1:0]  exp_q;
    logic                     sign_q;
    logic [23:0]              mant_q;
    logic                     guard_q, sticky_q;
    logic                     done_q;

    // ---------------- operand decode (denormals behave as zero) ----------------
    logic [7:0] w_a_exp, w_b_exp;
    logic       w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_sign;

    assign w_a_exp  = a_q[30:23];
    assign w_b_exp  = b_q[30:23];
    assign w_a_nan  = (&w_a_exp) & (|a_q[22:0]);
    assign w_b_nan  = (&w_b_exp) & (|b_q[22:0]);
    assign w_a_inf  = (&w_a_exp) & ~(|a_q[22:0]);
    assign w_b_inf  = (&w_b_exp) & ~(|b_q[22:0]);
    assign w_a_zero = (w_a_exp == 8'd0);
    assign w_b_zero = (w_b_exp == 8'd0);
    assign w_sign   = a_q[31] ^ b_q[31];

    logic        w_special, w_sp_inv, w_sp_dbz;
    logic [31:0] w_sp_res;

    always_comb begin
        w_special = 1'b1;
        w_sp_inv  = 1'b0;
        w_sp_dbz  = 1'b0;
        w_sp_res  = 32'd0;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_sp_res = c_QNAN;
            w_sp_inv = 1'b1;
        end else if (w_a_inf) begin
            w_sp_res = {w_sign, 8'hFF, 23'd0};
        end else if (w_b_zero) begin
            w_sp_res = {w_sign, 8'hFF, 23'd0};
            w_sp_dbz = 1'b1;
        end else if (w_b_inf || w_a_zero) begin
            w_sp_res = {w_sign, 31'd0};
        end else begin
            w_special = 1'b0;
        end
    end

    // ---------------- restoring division step ----------------
    logic [24:0] w_diff;
    logic        w_ge;
    logic [24:0] w_rem_next;

    assign w_diff     = rem_q - {1'b0, mb_q};
    assign w_ge       = (rem_q >= {1'b0, mb_q});
    // After a successful subtract rem < mb < 2^24, so the shift never loses a bit.
    assign w_rem_next = (w_ge ? w_diff : rem_q) << 1;

    // ---------------- rounding ----------------
    logic                    w_inc;
    logic [24:0]             w_mant_r;
    logic [23:0]             w_mant_f;
    logic signed [EXP_W-1:0] w_exp_r;

    assign w_inc    = guard_q & (sticky_q | mant_q[0]);
    assign w_mant_r = {1'b0, mant_q} + {24'd0, w_inc};
    assign w_mant_f = w_mant_r[24] ? w_mant_r[24:1] : w_mant_r[23:0];
    assign w_exp_r  = exp_q + (w_mant_r[24] ? EXP_W'(1) : EXP_W'(0));

    // ---------------- state machine ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CHECK;
            S_CHECK: state_d = w_special ? S_DONE : S_DIV;
            S_DIV:   if (cnt_q == '0) state_d = S_NORM;
            S_NORM:  state_d = S_ROUND;
            S_ROUND: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            // done trails the DONE state by one cycle so it coincides with busy low
            done_q  <= (state_q == S_DONE);
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q              <= '0;
            b_q              <= '0;
            rem_q            <= '0;
            mb_q             <= '0;
            q_q              <= '0;
            cnt_q            <= '0;
            exp_q            <= '0;
            sign_q           <= 1'b0;
            mant_q           <= '0;
            guard_q          <= 1'b0;
            sticky_q         <= 1'b0;
            result           <= '0;
            overflow_flag    <= 1'b0;
            underflow_flag   <= 1'b0;
            div_by_zero_flag <= 1'b0;
            invalid_flag     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    a_q              <= A;
                    b_q              <= B;
                    overflow_flag    <= 1'b0;
                    underflow_flag   <= 1'b0;
                    div_by_zero_flag <= 1'b0;
                    invalid_flag     <= 1'b0;
                end
                S_CHECK: begin
                    if (w_special) begin
                        result       <= w_sp_res;
                        invalid_flag     <= w_sp_inv;
                        div_by_zero_flag <= w_sp_dbz;
                    end else begin
                        rem_q  <= {2'b01, a_q[22:0]};
                        mb_q   <= {1'b1, b_q[22:0]};
                        q_q    <= '0;
                        cnt_q  <= CNT_W'(QBITS - 1);
                        sign_q <= w_sign;
                        exp_q  <= $signed({{(EXP_W-8){1'b0}}, w_a_exp})
                                - $signed({{(EXP_W-8){1'b0}}, w_b_exp}) + c_BIAS;
                    end
                end
                S_DIV: begin
                    q_q   <= {q_q[QBITS-2:0], w_ge};
                    rem_q <= w_rem_next;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                S_NORM: begin
                    if (q_q[QBITS-1]) begin
                        mant_q   <= q_q[QBITS-1 -: 24];
                        guard_q  <= q_q[QBITS-25];
                        sticky_q <= q_q[QBITS-26] | (|rem_q);
                    end else begin
                        mant_q   <= q_q[QBITS-2 -: 24];
                        guard_q  <= q_q[QBITS-26];
                        sticky_q <= |rem_q;
                        exp_q    <= exp_q - EXP_W'(1);
                    end
                end
                S_ROUND: begin
                    if (w_exp_r >= c_EXP_MAX) begin
                        result        <= {sign_q, 8'hFF, 23'd0};
                        overflow_flag <= 1'b1;
                    end else if (w_exp_r <= c_EXP_MIN) begin
                        result         <= {sign_q, 31'd0};
                        underflow_flag <= 1'b1;
                    end else begin
                        result <= {sign_q, w_exp_r[7:0], w_mant_f[22:0]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_div_seq.sv
//==============================================================================
// Module      : tb_fp_div_seq
// Description : Directed self-checking bench for fp_div_seq.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fp_div_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] A, B;
    logic        busy, done;
    logic [31:0] result;
    logic        overflow_flag, underflow_flag, div_by_zero_flag, invalid_flag;

    int n_checks;
    int n_fails;

    fp_div_seq dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .A                (A),
        .B                (B),
        .busy             (busy),
        .done             (done),
        .result           (result),
        .overflow_flag    (overflow_flag),
        .underflow_flag   (underflow_flag),
        .div_by_zero_flag (div_by_zero_flag),
        .invalid_flag     (invalid_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // flags packed as {overflow, underflow, div_by_zero, invalid}
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_res, input logic [3:0] exp_flags,
                           input int exp_lat);
        int  lat;
        bit  got;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; got = 0;
        while (!got && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (done) got = 1;
        end
        check({tag, " done_seen"}, 64'(got), 64'd1);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, 64'(result), 64'(exp_res));
        check({tag, " flags"},
              64'({overflow_flag, underflow_flag, div_by_zero_flag, invalid_flag}),
              64'(exp_flags));
        check({tag, " busy_at_done"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
        check({tag, " done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int dones;
        n_checks = 0;
        n_fails  = 0;
        reset = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs",
              64'({busy, done, overflow_flag, underflow_flag, div_by_zero_flag, invalid_flag}),
              64'd0);
        check("reset result", 64'(result), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_div("6/2",       32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 30);
        run_div("1/3",       32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 30);
        run_div("-1/3",      32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 4'b0000, 30);
        run_div("-6/2",      32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 30);
        run_div("1/0",       32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0010, 2);
        run_div("0/0",       32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0001, 2);
        run_div("inf/-inf",  32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b0001, 2);
        run_div("nan/1",     32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0001, 2);
        run_div("inf/-2",    32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000, 2);
        run_div("2/inf",     32'h40000000, 32'h7F800000, 32'h00000000, 4'b0000, 2);
        run_div("0/-2",      32'h00000000, 32'hC0000000, 32'h80000000, 4'b0000, 2);
        run_div("overflow",  32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b1000, 30);
        run_div("underflow", 32'h00800000, 32'h40000000, 32'h00000000, 4'b0100, 30);
        run_div("flags_clr", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 30);

        // start pulsed while busy must be ignored: exactly one done, first operands' result
        @(negedge clk);
        A = 32'h40C00000; B = 32'h40000000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        A = 32'h3F800000; B = 32'h00000000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk); #1;
            if (done) begin
                dones++;
                check("busy_ignore result", 64'(result), 64'h40400000);
            end
        end
        check("busy_ignore done_count", 64'(dones), 64'd1);
        check("busy_ignore no_flag", 64'(div_by_zero_flag), 64'd0);

        // reset during DIV aborts with no done
        @(negedge clk);
        A = 32'h3F800000; B = 32'h40400000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check("mid busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("abort outputs",
              64'({busy, done, overflow_flag, underflow_flag, div_by_zero_flag, invalid_flag}),
              64'd0);
        check("abort result", 64'(result), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("abort no_done", 64'(dones), 64'd0);
        run_div("after_abort", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
